md_unit_e: RTL

//  E-stage multiply/divide unit for the 5-stage MIPS pipeline. Executes mult/multu/div/divu/mthi/mtlo

---
 rtl/md_unit_e.sv | 128 ++++++++++++
 1 files changed

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: fixed-latency mult/div into a 64-bit shadow, retired into HI/LO.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu (md_op 7..10).
module md_unit_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [3:0]  cnt, cnt_next;
  logic [63:0] shadow, shadow_next;
  logic [31:0] hi_next, lo_next;
  state_t      state;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, b_mag_div, b_div;
  logic [31:0]        uq, ur, sq_mag, sr_mag, sq, sr;

  // The counter is the state register; IDLE/RUN is just a view of it.
  assign state = (cnt != 4'd0) ? RUN : IDLE;
  assign busy  = (state == RUN);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag     = a[31] ? -a : a;
  assign b_mag     = b[31] ? -b : b;
  assign b_mag_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_div     = (b == 32'd0) ? 32'd1 : b;
  assign uq        = a / b_div;
  assign ur        = a % b_div;
  assign sq_mag    = a_mag / b_mag_div;
  assign sr_mag    = a_mag % b_mag_div;
  assign sq        = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
  assign sr        = a[31] ? -sr_mag : sr_mag;

  always_comb begin
    cnt_next    = cnt;
    shadow_next = shadow;
    hi_next     = hi;
    lo_next     = lo;
    if (state == RUN) begin
      cnt_next = cnt - 4'd1;
      if (cnt == 4'd1) {hi_next, lo_next} = shadow;
    end else if (start) begin
      case (md_op)
        OP_MULT: begin
          shadow_next = $unsigned(prod_s);
          cnt_next    = 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          shadow_next = prod_u;
          cnt_next    = 4'(MULT_CYCLES);
        end
        // Divide by zero re-retires the current HI/LO so they appear untouched.
        OP_DIV: begin
          shadow_next = (b == 32'd0) ? {hi, lo} : {sr, sq};
          cnt_next    = 4'(DIV_CYCLES);
        end
        OP_DIVU: begin
          shadow_next = (b == 32'd0) ? {hi, lo} : {ur, uq};
          cnt_next    = 4'(DIV_CYCLES);
        end
        OP_MTHI: hi_next = a;
        OP_MTLO: lo_next = a;
`ifdef MD_MADD_EN
        OP_MADD: begin
          shadow_next = {hi, lo} + $unsigned(prod_s);
          cnt_next    = 4'(MULT_CYCLES);
        end
        OP_MADDU: begin
          shadow_next = {hi, lo} + prod_u;
          cnt_next    = 4'(MULT_CYCLES);
        end
        OP_MSUB: begin
          shadow_next = {hi, lo} - $unsigned(prod_s);
          cnt_next    = 4'(MULT_CYCLES);
        end
        OP_MSUBU: begin
          shadow_next = {hi, lo} - prod_u;
          cnt_next    = 4'(MULT_CYCLES);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      shadow <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      cnt    <= cnt_next;
      shadow <= shadow_next;
      hi     <= hi_next;
      lo     <= lo_next;
    end
  end

endmodule
